// File: rtl/ray_bounce_ctrl_pkg.sv
// Shared types and constants for the ray bounce sequencer: FSM states, retire
// status codes and fp24 colour helpers.
package ray_bounce_ctrl_pkg;

   localparam logic [23:0] FP24_ONE   = 24'h3f0000;
   localparam logic [71:0] FP24_WHITE = {3{FP24_ONE}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_HIT  = 3'd2,
      ST_WAIT_RFLX = 3'd3,
      ST_RETIRE    = 3'd4
   } ray_state_t;

   typedef enum logic [1:0] {
      PS_MAX_BOUNCE = 2'd0,
      PS_MISS       = 2'd1,
      PS_ABSORBED   = 2'd2,
      PS_TIMEOUT    = 2'd3
   } pix_status_t;

   // A component counts as zero when its exponent field is zero (denormals flushed).
   function automatic logic fp24_is_zero(input logic [23:0] v);
      return (v[22:16] == 7'd0);
   endfunction

   function automatic logic color_is_absorbed(input logic [71:0] c);
      return fp24_is_zero(c[71:48]) && fp24_is_zero(c[47:24]) && fp24_is_zero(c[23:0]);
   endfunction

endpackage

// File: rtl/ray_bounce_ctrl_watchdog_counter.sv
// Up-counting watchdog: cleared on a new trace issue, counts while enabled and
// holds at the limit, flagging expiry at TIMEOUT_CYCLES-1.
module watchdog_counter #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] r_count;
   logic          w_expired;

   assign w_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));
   assign o_expired = w_expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_expired) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/ray_bounce_ctrl.sv
// Per-ray bounce sequencer: takes a primary ray, drives the intersector and
// ray_reflector, re-issues bounced rays and retires the pixel's light.
//
//  state        | meaning
//  -------------+----------------------------------------------------------
//  ST_IDLE      | waiting for a primary ray (gen_ready high)
//  ST_ISSUE     | ray offered to the intersector (trace_valid high)
//  ST_WAIT_HIT  | waiting for hit/miss, watchdog running
//  ST_WAIT_RFLX | reflector working on the hit, watchdog running
//  ST_RETIRE    | pixel result offered to the accumulator (pix_valid high)
module ray_bounce_ctrl
   import ray_bounce_ctrl_pkg::*;
#(
   parameter int MAX_BOUNCES    = 4,
   parameter int PIX_W          = 17,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gen_valid,
   output logic             gen_ready,
   input  logic [71:0]      gen_origin,
   input  logic [71:0]      gen_dir,
   input  logic [PIX_W-1:0] gen_pixel,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [71:0]      trace_origin,
   output logic [71:0]      trace_dir,
   input  logic             hit_valid,
   input  logic             hit_miss,
   output logic [71:0]      rflx_ray_color,
   output logic [71:0]      rflx_income_light,
   input  logic             reflect_done,
   input  logic [71:0]      new_dir,
   input  logic [71:0]      new_origin,
   input  logic [71:0]      new_color,
   input  logic [71:0]      new_income_light,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [71:0]      pix_light,
   output logic [PIX_W-1:0] pix_idx,
   output logic [1:0]       pix_status
);

   localparam int BW = $clog2(MAX_BOUNCES + 1);

   ray_state_t       r_state;
   pix_status_t      r_status;
   logic             r_gen_ready;
   logic             r_trace_valid;
   logic             r_pix_valid;
   logic [71:0]      r_origin;
   logic [71:0]      r_dir;
   logic [71:0]      r_ray_color;
   logic [71:0]      r_income_light;
   logic [PIX_W-1:0] r_pixel;
   logic [BW-1:0]    r_bounces;

   logic             w_wd_clear;
   logic             w_wd_enable;
   logic             w_wd_expired;
   logic [BW-1:0]    w_bounces_nxt;

   assign w_wd_clear    = (r_state == ST_ISSUE) && trace_ready;
   assign w_wd_enable   = (r_state == ST_WAIT_HIT) || (r_state == ST_WAIT_RFLX);
   assign w_bounces_nxt = r_bounces + BW'(1);

   watchdog_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_wd_clear),
      .i_enable (w_wd_enable),
      .o_expired(w_wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_status       <= PS_MAX_BOUNCE;
         r_gen_ready    <= 1'b0;
         r_trace_valid  <= 1'b0;
         r_pix_valid    <= 1'b0;
         r_origin       <= '0;
         r_dir          <= '0;
         r_ray_color    <= '0;
         r_income_light <= '0;
         r_pixel        <= '0;
         r_bounces      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (gen_valid && r_gen_ready) begin
                  r_origin       <= gen_origin;
                  r_dir          <= gen_dir;
                  r_pixel        <= gen_pixel;
                  r_ray_color    <= FP24_WHITE;
                  r_income_light <= '0;
                  r_bounces      <= '0;
                  r_gen_ready    <= 1'b0;
                  r_trace_valid  <= 1'b1;
                  r_state        <= ST_ISSUE;
               end else begin
                  r_gen_ready <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (trace_ready) begin
                  r_trace_valid <= 1'b0;
                  r_state       <= ST_WAIT_HIT;
               end
            end
            ST_WAIT_HIT: begin
               // A hit beats a simultaneous miss, and any event beats expiry.
               if (hit_valid) begin
                  r_state <= ST_WAIT_RFLX;
               end else if (hit_miss) begin
                  r_status    <= PS_MISS;
                  r_pix_valid <= 1'b1;
                  r_state     <= ST_RETIRE;
               end else if (w_wd_expired) begin
                  r_status    <= PS_TIMEOUT;
                  r_pix_valid <= 1'b1;
                  r_state     <= ST_RETIRE;
               end
            end
            ST_WAIT_RFLX: begin
               if (reflect_done) begin
                  r_dir          <= new_dir;
                  r_origin       <= new_origin;
                  r_ray_color    <= new_color;
                  r_income_light <= new_income_light;
                  r_bounces      <= w_bounces_nxt;
                  if (w_bounces_nxt == BW'(MAX_BOUNCES)) begin
                     r_status    <= PS_MAX_BOUNCE;
                     r_pix_valid <= 1'b1;
                     r_state     <= ST_RETIRE;
                  end else if (color_is_absorbed(new_color)) begin
                     r_status    <= PS_ABSORBED;
                     r_pix_valid <= 1'b1;
                     r_state     <= ST_RETIRE;
                  end else begin
                     r_trace_valid <= 1'b1;
                     r_state       <= ST_ISSUE;
                  end
               end else if (w_wd_expired) begin
                  r_status    <= PS_TIMEOUT;
                  r_pix_valid <= 1'b1;
                  r_state     <= ST_RETIRE;
               end
            end
            ST_RETIRE: begin
               if (pix_ready) begin
                  r_pix_valid <= 1'b0;
                  r_gen_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gen_ready         = r_gen_ready;
   assign trace_valid       = r_trace_valid;
   assign trace_origin      = r_origin;
   assign trace_dir         = r_dir;
   assign rflx_ray_color    = r_ray_color;
   assign rflx_income_light = r_income_light;
   assign pix_valid         = r_pix_valid;
   assign pix_light         = r_income_light;
   assign pix_idx           = r_pixel;
   assign pix_status        = r_status;

endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// Scoreboard bench for ray_bounce_ctrl: stimulus queues expected trace and pixel
// transactions, a negedge monitor pops and compares them on each handshake.
module tb_ray_bounce_ctrl;

   localparam int PIX_W = 17;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             gen_valid, gen_ready;
   logic [71:0]      gen_origin, gen_dir;
   logic [PIX_W-1:0] gen_pixel;
   logic             trace_valid, trace_ready;
   logic [71:0]      trace_origin, trace_dir;
   logic             hit_valid, hit_miss;
   logic [71:0]      rflx_ray_color, rflx_income_light;
   logic             reflect_done;
   logic [71:0]      new_dir, new_origin, new_color, new_income_light;
   logic             pix_valid, pix_ready;
   logic [71:0]      pix_light;
   logic [PIX_W-1:0] pix_idx;
   logic [1:0]       pix_status;

   always #5 clk = ~clk;

   ray_bounce_ctrl #(
      .MAX_BOUNCES(4),
      .PIX_W(PIX_W),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_origin(gen_origin),
      .gen_dir(gen_dir), .gen_pixel(gen_pixel),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_origin(trace_origin), .trace_dir(trace_dir),
      .hit_valid(hit_valid), .hit_miss(hit_miss),
      .rflx_ray_color(rflx_ray_color), .rflx_income_light(rflx_income_light),
      .reflect_done(reflect_done), .new_dir(new_dir), .new_origin(new_origin),
      .new_color(new_color), .new_income_light(new_income_light),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_light(pix_light),
      .pix_idx(pix_idx), .pix_status(pix_status)
   );

   typedef struct packed {
      logic [71:0] o;
      logic [71:0] d;
   } trace_t;

   typedef struct packed {
      logic [71:0]      light;
      logic [PIX_W-1:0] idx;
      logic [1:0]       st;
   } pix_t;

   localparam logic [71:0] WHITE = {3{24'h3f0000}};
   localparam logic [71:0] GREY  = {3{24'h3e0000}};

   trace_t trace_q[$];
   pix_t   pix_q[$];
   int     n_checks = 0;
   int     n_errors = 0;
   int     n_trace_hs = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return gen_ready;
         1:       return trace_valid;
         default: return pix_valid;
      endcase
   endfunction

   task automatic wait_hi(input string name, input int which);
      for (int i = 0; i < 200; i++) begin
         if (sig(which)) return;
         tick();
      end
      chk(name, 72'(sig(which)), 72'(1));
   endtask

   task automatic push_trace(input logic [71:0] o, input logic [71:0] d);
      trace_t t;
      t.o = o;
      t.d = d;
      trace_q.push_back(t);
   endtask

   task automatic push_pix(input logic [71:0] l, input logic [PIX_W-1:0] idx, input logic [1:0] st);
      pix_t p;
      p.light = l;
      p.idx   = idx;
      p.st    = st;
      pix_q.push_back(p);
   endtask

   task automatic send_gen(input logic [71:0] o, input logic [71:0] d, input logic [PIX_W-1:0] idx);
      wait_hi("gen_ready wait", 0);
      gen_origin = o;
      gen_dir    = d;
      gen_pixel  = idx;
      push_trace(o, d);
      gen_valid = 1'b1;
      tick();
      gen_valid = 1'b0;
   endtask

   task automatic trace_accept();
      wait_hi("trace_valid wait", 1);
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
   endtask

   task automatic pix_accept();
      wait_hi("pix_valid wait", 2);
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
   endtask

   task automatic pulse_hit();
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
   endtask

   task automatic pulse_miss();
      hit_miss = 1'b1;
      tick();
      hit_miss = 1'b0;
   endtask

   task automatic reflect(input logic [71:0] d, input logic [71:0] o,
                          input logic [71:0] c, input logic [71:0] l);
      new_dir          = d;
      new_origin       = o;
      new_color        = c;
      new_income_light = l;
      reflect_done     = 1'b1;
      tick();
      reflect_done     = 1'b0;
   endtask

   // Monitor: compares every trace and pixel handshake against the queues.
   initial begin
      trace_t te;
      pix_t   pe;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (trace_valid && trace_ready) begin
               n_trace_hs++;
               if (trace_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected trace handshake: origin %h none expected", trace_origin);
               end else begin
                  te = trace_q.pop_front();
                  chk("trace_origin", trace_origin, te.o);
                  chk("trace_dir", trace_dir, te.d);
               end
            end
            if (pix_valid && pix_ready) begin
               if (pix_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected pixel retire: idx %0d none expected", pix_idx);
               end else begin
                  pe = pix_q.pop_front();
                  chk("pix_light", pix_light, pe.light);
                  chk("pix_idx", 72'(pix_idx), 72'(pe.idx));
                  chk("pix_status", 72'(pix_status), 72'(pe.st));
               end
            end
         end
      end
   end

   initial begin
      int          hs0;
      logic [71:0] lb, nd, no;
      gen_valid = 0; gen_origin = '0; gen_dir = '0; gen_pixel = '0;
      trace_ready = 0; hit_valid = 0; hit_miss = 0; reflect_done = 0;
      new_dir = '0; new_origin = '0; new_color = '0; new_income_light = '0;
      pix_ready = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset gen_ready", 72'(gen_ready), 72'(0));
      chk("reset trace_valid", 72'(trace_valid), 72'(0));
      chk("reset pix_valid", 72'(pix_valid), 72'(0));
      chk("reset pix_status", 72'(pix_status), 72'(0));
      chk("reset trace_origin", trace_origin, 72'(0));
      rst_n = 1'b1;
      tick();
      chk("gen_ready after reset", 72'(gen_ready), 72'(1));

      // One bounce then a miss
      send_gen(72'h3f0000_3f8000_400000, 72'h3f0000_000000_000000, 17'd100);
      chk("gen->trace latency", 72'(trace_valid), 72'(1));
      trace_accept();
      pulse_hit();
      chk("rflx_ray_color white", rflx_ray_color, WHITE);
      chk("rflx_income_light zero", rflx_income_light, 72'(0));
      push_trace(72'h401000_402000_403000, 72'h000000_3f0000_000000);
      reflect(72'h000000_3f0000_000000, 72'h401000_402000_403000, GREY, GREY);
      chk("reflect->trace latency", 72'(trace_valid), 72'(1));
      trace_accept();
      chk("rflx_ray_color grey", rflx_ray_color, GREY);
      push_pix(GREY, 17'd100, 2'd1);
      pulse_miss();
      chk("miss->pix latency", 72'(pix_valid), 72'(1));
      pix_accept();

      // Four bounces: forced retire
      send_gen(72'h3e0000_3e0000_3e0000, 72'h000000_000000_3f0000, 17'd7);
      hs0 = n_trace_hs;
      for (int b = 0; b < 4; b++) begin
         trace_accept();
         pulse_hit();
         lb = {3{24'h3d0000 + 24'(b)}};
         nd = 72'h3f0000_000000_000000 + 72'(b);
         no = 72'h410000_410000_410000 + 72'(b);
         if (b < 3) push_trace(no, nd);
         else       push_pix(lb, 17'd7, 2'd0);
         reflect(nd, no, {3{24'h3e8000}}, lb);
      end
      chk("max bounce no trace", 72'(trace_valid), 72'(0));
      chk("max bounce pix_valid", 72'(pix_valid), 72'(1));
      pix_accept();
      repeat (3) tick();
      chk("max bounce no 5th trace", 72'(trace_valid), 72'(0));
      chk("four trace handshakes", 72'(n_trace_hs - hs0), 72'(4));

      // Hit beats simultaneous miss, then absorbed colour
      send_gen(72'h3f0000_3f0000_3f0000, 72'h000000_3f0000_000000, 17'd9);
      trace_accept();
      hit_valid = 1'b1;
      hit_miss  = 1'b1;
      tick();
      hit_valid = 1'b0;
      hit_miss  = 1'b0;
      chk("hit wins over miss", 72'(pix_valid), 72'(0));
      push_pix({3{24'h3c1234}}, 17'd9, 2'd2);
      reflect(72'h3f0000_000000_000000, 72'h0, 72'h80ffff_00ffff_001234, {3{24'h3c1234}});
      chk("absorbed retire latency", 72'(pix_valid), 72'(1));
      chk("absorbed no trace", 72'(trace_valid), 72'(0));
      pix_accept();

      // Trace stall with spurious pulses, then watchdog timeout
      send_gen(72'h3f1111_3f2222_3f3333, 72'h3f0000_3f0000_000000, 17'd55);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) reflect_done = 1'b1;
         if (i == 7) hit_valid = 1'b1;
         tick();
         reflect_done = 1'b0;
         hit_valid    = 1'b0;
         chk("stall trace_valid", 72'(trace_valid), 72'(1));
         chk("stall trace_origin", trace_origin, 72'h3f1111_3f2222_3f3333);
      end
      chk("stall trace_dir", trace_dir, 72'h3f0000_3f0000_000000);
      trace_accept();
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 63) chk("timeout not early", 72'(pix_valid), 72'(0));
         if (k == 64) chk("timeout at 64", 72'(pix_valid), 72'(1));
      end
      push_pix(72'h0, 17'd55, 2'd3);
      gen_origin = 72'h3a0000_3b0000_3c0000;
      gen_dir    = 72'h000000_000000_3f0000;
      gen_pixel  = 17'd77;
      gen_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("pix stall gen_ready", 72'(gen_ready), 72'(0));
         chk("pix stall pix_status", 72'(pix_status), 72'(3));
      end
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      chk("idle cycle no accept", 72'(trace_valid), 72'(0));
      chk("idle cycle gen_ready", 72'(gen_ready), 72'(1));
      push_trace(72'h3a0000_3b0000_3c0000, 72'h000000_000000_3f0000);
      tick();
      gen_valid = 1'b0;
      chk("accept after idle", 72'(trace_valid), 72'(1));

      // Reset while waiting on the reflector
      trace_accept();
      pulse_hit();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset trace_valid", 72'(trace_valid), 72'(0));
      chk("async reset pix_valid", 72'(pix_valid), 72'(0));
      chk("async reset gen_ready", 72'(gen_ready), 72'(0));
      chk("async reset rflx_ray_color", rflx_ray_color, 72'(0));
      chk("async reset trace_origin", trace_origin, 72'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reflect(72'h3f0000_3f0000_3f0000, 72'h3f0000_3f0000_3f0000, GREY, GREY);
      chk("late reflect no trace", 72'(trace_valid), 72'(0));
      chk("late reflect no pix", 72'(pix_valid), 72'(0));
      chk("late reflect rflx_income_light", rflx_income_light, 72'(0));
      send_gen(72'h400000_400000_400000, 72'h3f0000_000000_000000, 17'd200);
      trace_accept();
      push_pix(72'h0, 17'd200, 2'd1);
      pulse_miss();
      pix_accept();

      repeat (3) tick();
      chk("trace queue drained", 72'(trace_q.size()), 72'(0));
      chk("pix queue drained", 72'(pix_q.size()), 72'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
